// File: rtl/sindoku_pkg.sv
// Shared types and constants for the sindoku board: state encoding, board size,
// the fixed puzzle, its solution and the mask of given (clue) cells.
package sindoku_pkg;

    localparam int unsigned N     = 9;
    localparam int unsigned CELLS = N * N;

    // One-hot encoding so the q_* flags are plain register bits.
    typedef enum logic [4:0] {
        StIni       = 5'b00001,
        StSolve     = 5'b00010,
        StCheck     = 5'b00100,
        StCorrect   = 5'b01000,
        StIncorrect = 5'b10000
    } state_e;

    typedef logic [CELLS-1:0][3:0] board_t;

    // Rows are written one hex digit per cell, row 0 leftmost; cell 0 lands at index 0.
    function automatic board_t rows_to_board(input logic [CELLS*4-1:0] rows);
        board_t b;
        for (int unsigned i = 0; i < CELLS; i++) begin
            b[i] = rows[(CELLS-1-i)*4 +: 4];
        end
        return b;
    endfunction

    function automatic logic [CELLS-1:0] given_mask(input board_t b);
        logic [CELLS-1:0] m;
        for (int unsigned i = 0; i < CELLS; i++) begin
            m[i] = (b[i] != 4'd0);
        end
        return m;
    endfunction

    localparam board_t PUZZLE = rows_to_board({
        36'h530070000, 36'h600195000, 36'h098000060,
        36'h800060003, 36'h400803001, 36'h700020006,
        36'h060000280, 36'h000419005, 36'h000080079
    });

    localparam board_t SOLUTION = rows_to_board({
        36'h534678912, 36'h672195348, 36'h198342567,
        36'h859761423, 36'h426853791, 36'h713924856,
        36'h961537284, 36'h287419635, 36'h345286179
    });

    localparam logic [CELLS-1:0] GIVEN = given_mask(PUZZLE);

endpackage

// File: rtl/sindoku_cursor.sv
// Cursor row/column wrap counters with U > D > L > R move priority,
// a move enable and a synchronous reload to (0,0).
module sindoku_cursor #(
    parameter int unsigned N = 9
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       reload_i,
    input  logic       up_i,
    input  logic       down_i,
    input  logic       left_i,
    input  logic       right_i,
    output logic [3:0] row_o,
    output logic [3:0] col_o
);

    localparam logic [3:0] Last = 4'(N - 1);

    logic [3:0] row_d, row_q, col_d, col_q;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (reload_i) begin
            row_d = '0;
            col_d = '0;
        end else if (en_i) begin
            if (up_i) begin
                row_d = (row_q == 4'd0) ? Last : row_q - 4'd1;
            end else if (down_i) begin
                row_d = (row_q == Last) ? 4'd0 : row_q + 4'd1;
            end else if (left_i) begin
                col_d = (col_q == 4'd0) ? Last : col_q - 4'd1;
            end else if (right_i) begin
                col_d = (col_q == Last) ? 4'd0 : col_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o = row_q;
    assign col_o = col_q;

endmodule

// File: rtl/sindoku_board.sv
// Sudoku game board: cursor-driven cell entry, a cell-per-cycle solution check
// and the INI/SOLVE/CHECK/CORRECT/INCORRECT game flow.
module sindoku_board #(
    parameter int unsigned N = sindoku_pkg::N
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       R,
    input  logic       L,
    input  logic       U,
    input  logic       D,
    input  logic       C,
    input  logic       CheckSolu,
    input  logic [3:0] userIn,
    output logic       q_I,
    output logic       q_Solve,
    output logic       q_Check,
    output logic       q_Correct,
    output logic       q_Incorrect,
    output logic [3:0] cur_row,
    output logic [3:0] cur_col,
    output logic [3:0] cur_val,
    output logic       cur_given,
    output logic [6:0] err_idx
);

    import sindoku_pkg::*;

    state_e     state_q, state_d;
    board_t     board_q, board_d;
    logic [6:0] idx_q, idx_d;
    logic [6:0] err_q, err_d;
    logic [6:0] cur_idx;
    logic       cur_en, cur_reload;

    sindoku_cursor #(
        .N(N)
    ) u_cursor (
        .clk_i   (Clk),
        .rst_ni  (Reset),
        .en_i    (cur_en),
        .reload_i(cur_reload),
        .up_i    (U),
        .down_i  (D),
        .left_i  (L),
        .right_i (R),
        .row_o   (cur_row),
        .col_o   (cur_col)
    );

    assign cur_idx   = 7'(cur_row * N + cur_col);
    assign cur_val   = board_q[cur_idx];
    assign cur_given = GIVEN[cur_idx];

    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        idx_d      = idx_q;
        err_d      = err_q;
        cur_en     = 1'b0;
        cur_reload = 1'b0;
        unique case (state_q)
            StIni: begin
                if (C) state_d = StSolve;
            end
            StSolve: begin
                if (CheckSolu) begin
                    state_d = StCheck;
                    idx_d   = '0;
                end else begin
                    // Write uses the pre-move cursor; the move lands in the same update.
                    cur_en = 1'b1;
                    if (C && !GIVEN[cur_idx] && (userIn <= 4'(N))) begin
                        board_d[cur_idx] = userIn;
                    end
                end
            end
            StCheck: begin
                if (board_q[idx_q] != SOLUTION[idx_q]) begin
                    state_d = StIncorrect;
                    err_d   = idx_q;
                end else if (idx_q == 7'(CELLS - 1)) begin
                    state_d = StCorrect;
                end else begin
                    idx_d = idx_q + 7'd1;
                end
            end
            StIncorrect: begin
                if (!CheckSolu) state_d = StSolve;
            end
            StCorrect: begin
                if (C) begin
                    state_d    = StIni;
                    board_d    = PUZZLE;
                    err_d      = '0;
                    cur_reload = 1'b1;
                end
            end
            default: state_d = StIni;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= StIni;
            board_q <= PUZZLE;
            idx_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    assign q_I         = state_q[0];
    assign q_Solve     = state_q[1];
    assign q_Check     = state_q[2];
    assign q_Correct   = state_q[3];
    assign q_Incorrect = state_q[4];
    assign err_idx     = err_q;

endmodule

// File: tb/tb_sindoku_board.sv
// Directed bench for sindoku_board: cursor wrap/priority, cell entry rules,
// full check to CORRECT, check stopping at a wrong cell, and reset mid-check.
module tb_sindoku_board;

    logic       Clk = 1'b0;
    logic       Reset, R, L, U, D, C, CheckSolu;
    logic [3:0] userIn;
    logic       q_I, q_Solve, q_Check, q_Correct, q_Incorrect;
    logic [3:0] cur_row, cur_col, cur_val;
    logic       cur_given;
    logic [6:0] err_idx;

    int checks   = 0;
    int failures = 0;
    int cycles;

    localparam logic [4:0] FlagIni   = 5'b10000;
    localparam logic [4:0] FlagSolve = 5'b01000;
    localparam logic [4:0] FlagCheck = 5'b00100;
    localparam logic [4:0] FlagOk    = 5'b00010;
    localparam logic [4:0] FlagBad   = 5'b00001;

    localparam logic [35:0] SOL_ROWS [9] = '{
        36'h534678912, 36'h672195348, 36'h198342567,
        36'h859761423, 36'h426853791, 36'h713924856,
        36'h961537284, 36'h287419635, 36'h345286179
    };

    always #5 Clk = ~Clk;

    sindoku_board #(
        .N(9)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .R          (R),
        .L          (L),
        .U          (U),
        .D          (D),
        .C          (C),
        .CheckSolu  (CheckSolu),
        .userIn     (userIn),
        .q_I        (q_I),
        .q_Solve    (q_Solve),
        .q_Check    (q_Check),
        .q_Correct  (q_Correct),
        .q_Incorrect(q_Incorrect),
        .cur_row    (cur_row),
        .cur_col    (cur_col),
        .cur_val    (cur_val),
        .cur_given  (cur_given),
        .err_idx    (err_idx)
    );

    function automatic logic [3:0] sol(input int r, input int c);
        logic [35:0] row;
        row = SOL_ROWS[r];
        return row[(8-c)*4 +: 4];
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic press(input logic u, input logic d, input logic l, input logic r,
                         input logic c);
        U = u; D = d; L = l; R = r; C = c;
        tick();
        U = 1'b0; D = 1'b0; L = 1'b0; R = 1'b0; C = 1'b0;
    endtask

    function automatic logic [4:0] flags();
        return {q_I, q_Solve, q_Check, q_Correct, q_Incorrect};
    endfunction

    // From (0,0): write each row with C+R (col wraps back to 0), then step down.
    task automatic fill_solution();
        for (int r = 0; r < 9; r++) begin
            for (int c = 0; c < 9; c++) begin
                userIn = sol(r, c);
                press(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            end
            press(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        Reset = 1'b1; R = 1'b0; L = 1'b0; U = 1'b0; D = 1'b0; C = 1'b0;
        CheckSolu = 1'b0; userIn = 4'd0;
        #3 Reset = 1'b0;
        #3;
        check_eq("reset_flags", 32'(flags()), 32'(FlagIni));
        check_eq("reset_row", 32'(cur_row), 0);
        check_eq("reset_col", 32'(cur_col), 0);
        check_eq("reset_err", 32'(err_idx), 0);
        check_eq("reset_val", 32'(cur_val), 5);
        check_eq("reset_given", 32'(cur_given), 1);
        @(negedge Clk) Reset = 1'b1;
        tick();

        press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("ini_ignores_move_flags", 32'(flags()), 32'(FlagIni));
        check_eq("ini_ignores_move_col", 32'(cur_col), 0);
        press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("start_flags", 32'(flags()), 32'(FlagSolve));

        press(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("left_wrap_row", 32'(cur_row), 0);
        check_eq("left_wrap_col", 32'(cur_col), 8);
        check_eq("cell08_val", 32'(cur_val), 0);
        check_eq("cell08_given", 32'(cur_given), 0);
        press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("right_wrap_col", 32'(cur_col), 0);
        press(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("up_over_right_row", 32'(cur_row), 8);
        check_eq("up_over_right_col", 32'(cur_col), 0);
        press(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("down_wrap_row", 32'(cur_row), 0);

        userIn = 4'd9;
        press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("given_unchanged", 32'(cur_val), 5);
        press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        userIn = 4'd12;
        press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("over_range_ignored", 32'(cur_val), 0);
        userIn = 4'd7;
        press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("write_7", 32'(cur_val), 7);
        userIn = 4'd0;
        press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("clear_cell", 32'(cur_val), 0);
        userIn = 4'd9;
        press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("write_max", 32'(cur_val), 9);
        press(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        fill_solution();
        check_eq("fill_home_row", 32'(cur_row), 0);
        check_eq("fill_home_col", 32'(cur_col), 0);

        // Hold moves during the scan; they must not reach the cursor.
        CheckSolu = 1'b1; R = 1'b1; U = 1'b1;
        tick();
        cycles = 0;
        while (q_Check && cycles < 200) begin
            cycles++;
            tick();
        end
        R = 1'b0; U = 1'b0;
        check_eq("check_cycles_full", 32'(cycles), 81);
        check_eq("correct_flags", 32'(flags()), 32'(FlagOk));
        check_eq("check_cursor_row", 32'(cur_row), 0);
        check_eq("check_cursor_col", 32'(cur_col), 0);
        CheckSolu = 1'b0;
        tick();
        check_eq("correct_holds", 32'(flags()), 32'(FlagOk));
        press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("restart_flags", 32'(flags()), 32'(FlagIni));
        check_eq("restart_err", 32'(err_idx), 0);
        press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("restart_board_reloaded", 32'(cur_val), 0);
        press(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        fill_solution();
        for (int i = 0; i < 4; i++) press(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("cell40_solution", 32'(cur_val), 5);
        userIn = 4'd1;
        press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("cell40_wrong", 32'(cur_val), 1);
        CheckSolu = 1'b1;
        tick();
        cycles = 0;
        while (q_Check && cycles < 200) begin
            cycles++;
            tick();
        end
        check_eq("check_cycles_err", 32'(cycles), 41);
        check_eq("incorrect_flags", 32'(flags()), 32'(FlagBad));
        check_eq("err_idx_40", 32'(err_idx), 40);
        for (int i = 0; i < 3; i++) tick();
        check_eq("incorrect_holds", 32'(flags()), 32'(FlagBad));
        CheckSolu = 1'b0;
        tick();
        check_eq("back_to_solve", 32'(flags()), 32'(FlagSolve));
        check_eq("kept_row", 32'(cur_row), 4);
        check_eq("kept_col", 32'(cur_col), 4);
        check_eq("kept_cell40", 32'(cur_val), 1);

        CheckSolu = 1'b1;
        tick();
        CheckSolu = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check_eq("mid_check_flags", 32'(flags()), 32'(FlagCheck));
        #2 Reset = 1'b0;
        #1;
        check_eq("async_reset_flags", 32'(flags()), 32'(FlagIni));
        check_eq("async_reset_row", 32'(cur_row), 0);
        check_eq("async_reset_col", 32'(cur_col), 0);
        check_eq("async_reset_err", 32'(err_idx), 0);
        #2 Reset = 1'b1;
        tick();
        press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) press(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("reset_board_puzzle", 32'(cur_val), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
